// File: rtl/f3m_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | f3m_arb_pkg : shared widths, state encoding and helpers for the            |
// |               f3m_mult arbiter.                                            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package f3m_arb_pkg;

  localparam int W2     = 193;
  localparam int ELEM_W = W2 + 1;
  localparam int N_MAX  = 4;
  localparam int PTR_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  function automatic logic [PTR_W-1:0] oh_to_idx(input logic [N_MAX-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/f3m_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | f3m_arb_pick : combinational winner selector (req, pointer -> one-hot).    |
// |   F3M_ARB_RR_EN defined   : round-robin starting at ptr_i.                 |
// |   F3M_ARB_RR_EN undefined : fixed priority, req_i[0] highest.              |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module f3m_arb_pick
  import f3m_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

`ifdef F3M_ARB_RR_EN
  // Walk from farthest to nearest so the candidate closest to ptr_i wins.
  always_comb begin
    gnt_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    gnt_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        gnt_o = '0;
        gnt_o[k] = 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/f3m_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | f3m_mult_arbiter : grant-locked sharing of one iterative f3m_mult between  |
// |                    up to four requesters. Policy macro: F3M_ARB_RR_EN.     |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module f3m_mult_arbiter
  import f3m_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic [N*ELEM_W-1:0] a,
  input  logic [N*ELEM_W-1:0] b,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        done,
  output logic [ELEM_W-1:0]   c,
  output logic                mult_reset,
  output logic [ELEM_W-1:0]   mult_a,
  output logic [ELEM_W-1:0]   mult_b,
  input  logic [ELEM_W-1:0]   mult_c,
  input  logic                mult_done
);

  arb_state_e          state_q;
  logic [N-1:0]        gnt_q;
  logic [N-1:0]        done_q;
  logic [ELEM_W-1:0]   c_q;
  logic [ELEM_W-1:0]   a_q;
  logic [ELEM_W-1:0]   b_q;
  logic                first_q;
  logic [N-1:0]        pick;
  logic [ELEM_W-1:0]   sel_a;
  logic [ELEM_W-1:0]   sel_b;

`ifdef F3M_ARB_RR_EN
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    ptr_d;
  logic [N_MAX-1:0]    gnt_ext;
  logic [PTR_W-1:0]    win_idx;

  always_comb begin
    gnt_ext        = '0;
    gnt_ext[N-1:0] = gnt_q;
    win_idx        = oh_to_idx(gnt_ext);
    ptr_d          = (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + 1'b1;
  end

  f3m_arb_pick #(.N(N)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );
`else
  f3m_arb_pick #(.N(N)) u_pick (
    .req_i (req),
    .ptr_i ({PTR_W{1'b0}}),
    .gnt_o (pick)
  );
`endif

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        sel_a = sel_a | a[i*ELEM_W +: ELEM_W];
        sel_b = sel_b | b[i*ELEM_W +: ELEM_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      first_q <= 1'b0;
`ifdef F3M_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= '0;
          if (|req) begin
            gnt_q   <= pick;
            a_q     <= sel_a;
            b_q     <= sel_b;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          first_q <= 1'b1;
          state_q <= ST_WAIT;
`ifdef F3M_ARB_RR_EN
          ptr_q   <= ptr_d;
`endif
        end
        // The first WAIT cycle may still see the previous operation's done level.
        ST_WAIT: begin
          if (first_q) begin
            first_q <= 1'b0;
          end else if (mult_done) begin
            c_q     <= mult_c;
            done_q  <= gnt_q;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          done_q  <= '0;
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign c          = c_q;
  assign mult_a     = a_q;
  assign mult_b     = b_q;
  assign mult_reset = reset | (state_q == ST_START);

endmodule
`default_nettype wire

// File: tb/tb_f3m_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_f3m_mult_arbiter : self-checking bench with a 5-cycle GF(3^97)          |
// |                       multiplier model and a result scoreboard.            |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_f3m_mult_arbiter;

  localparam int N  = 4;
  localparam int EW = 194;
  localparam int NT = 97;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*EW-1:0] a_bus, b_bus;
  logic [N-1:0]    gnt, done;
  logic [EW-1:0]   c, mult_a, mult_b, mult_c;
  logic            mult_reset, mult_done;
  logic [EW-1:0]   op_a [N];
  logic [EW-1:0]   op_b [N];

  int checks   = 0;
  int failures = 0;
  int starts   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  f3m_mult_arbiter #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .a          (a_bus),
    .b          (b_bus),
    .gnt        (gnt),
    .done       (done),
    .c          (c),
    .mult_reset (mult_reset),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_c     (mult_c),
    .mult_done  (mult_done)
  );

  always_comb begin
    a_bus = '0;
    b_bus = '0;
    for (int i = 0; i < N; i++) begin
      a_bus[i*EW +: EW] = op_a[i];
      b_bus[i*EW +: EW] = op_b[i];
    end
  end

  // Reference GF(3^97) product, reduction polynomial x^97 + x^12 + 2.
  function automatic logic [EW-1:0] gf_mul(input logic [EW-1:0] x, input logic [EW-1:0] y);
    int p [2*NT-1];
    logic [EW-1:0] r;
    for (int i = 0; i < 2*NT-1; i++) p[i] = 0;
    for (int i = 0; i < NT; i++)
      for (int j = 0; j < NT; j++)
        p[i+j] += int'(x[2*i +: 2]) * int'(y[2*j +: 2]);
    for (int d = 2*NT-2; d >= NT; d--) begin
      p[d-NT+12] += 2 * p[d];
      p[d-NT]    += p[d];
      p[d]        = 0;
    end
    for (int i = 0; i < NT; i++) r[2*i +: 2] = 2'(p[i] % 3);
    return r;
  endfunction

  function automatic logic [EW-1:0] rand_elem();
    logic [EW-1:0] r;
    for (int i = 0; i < NT; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic int oh2i(input logic [N-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Multiplier model: done level held until the next start; stale_lag delays the clear by one cycle.
  logic          stale_lag = 1'b0;
  logic          mr_q;
  logic          busy;
  logic [3:0]    cnt;
  logic [EW-1:0] ma_q, mb_q;

  always_ff @(posedge clk) begin
    mr_q <= mult_reset;
    if (stale_lag ? mr_q : mult_reset) begin
      busy      <= 1'b1;
      cnt       <= '0;
      mult_done <= 1'b0;
      ma_q      <= mult_a;
      mb_q      <= mult_b;
    end else if (busy) begin
      if (cnt == 4'd4) begin
        busy      <= 1'b0;
        mult_done <= 1'b1;
        mult_c    <= gf_mul(ma_q, mb_q);
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  typedef struct {
    logic [N-1:0]  who;
    logic [EW-1:0] prod;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  always @(negedge clk) begin
    if (!reset && mult_reset) starts++;
    if (done != '0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done done=%b gnt=%b", done, gnt);
      end else begin
        e_mon = sb.pop_front();
        if (done !== e_mon.who || gnt !== e_mon.who || c !== e_mon.prod) begin
          failures++;
          $display("FAIL resp done=%b gnt=%b want=%b c=%h want=%h", done, gnt, e_mon.who, c, e_mon.prod);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.who  = '0;
    e.who[i] = 1'b1;
    e.prod = gf_mul(op_a[i], op_b[i]);
    sb.push_back(e);
  endtask

  // Waits up to 40 cycles for any done pulse; returns 1 on timeout.
  task automatic wait_done(output bit timed_out);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (done == '0 && t < 40);
    timed_out = (done == '0);
  endtask

  task automatic settle_and_audit(input int s0, input int nops, input string name);
    repeat (20) @(negedge clk);
    chk({name, "_sb_empty"}, EW'(sb.size()), EW'(0));
    chk({name, "_starts"}, EW'(starts - s0), EW'(nops));
    sb.delete();
  endtask

  typedef struct packed {
    logic [N-1:0] req;
    logic         hold;
    logic [2:0]   nops;
    logic [19:0]  order;
  } vec_t;

  task automatic run_vec(input vec_t v, input bit chk_lat);
    int t0, got, s0;
    bit to;
    for (int i = 0; i < N; i++) begin
      op_a[i] = rand_elem();
      op_b[i] = rand_elem();
    end
    for (int k = 0; k < int'(v.nops); k++) push_exp(oh2i(v.order[4*k +: 4]));
    s0 = starts;
    @(negedge clk);
    req = v.req;
    t0  = cyc;
    got = 0;
    while (got < int'(v.nops)) begin
      wait_done(to);
      if (to) begin
        checks++;
        failures++;
        $display("FAIL timeout req=%b got=%0d", v.req, got);
        req = '0;
        break;
      end
      if (got == 0 && chk_lat) chk("latency", EW'(cyc - t0), EW'(8));
      got++;
      if (v.hold) begin
        if (got == int'(v.nops)) req = '0;
      end else begin
        req = req & ~done;
      end
    end
    settle_and_audit(s0, int'(v.nops), "vec");
  endtask

  vec_t vecs [5];

  initial begin : main
    int t0, s0;
    bit to;
    logic [EW-1:0] b0;

    vecs[0] = '{req: 4'b0001, hold: 1'b0, nops: 3'd1, order: 20'h00001};
    vecs[1] = '{req: 4'b1010, hold: 1'b0, nops: 3'd2, order: 20'h00082};
`ifdef F3M_ARB_RR_EN
    vecs[2] = '{req: 4'b1111, hold: 1'b1, nops: 3'd5, order: 20'h18421};
`else
    vecs[2] = '{req: 4'b1111, hold: 1'b1, nops: 3'd3, order: 20'h00111};
`endif
    vecs[3] = '{req: 4'b1100, hold: 1'b0, nops: 3'd2, order: 20'h00084};
    vecs[4] = '{req: 4'b0011, hold: 1'b0, nops: 3'd2, order: 20'h00021};

    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", EW'(gnt), EW'(0));
    chk("rst_done", EW'(done), EW'(0));
    chk("rst_c", c, '0);
    chk("rst_mult_a", mult_a, '0);
    chk("rst_mult_b", mult_b, '0);
    chk("rst_mult_reset", EW'(mult_reset), EW'(1));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed single request: a0 = 1 so the product is b0 itself.
    b0 = 194'h205aaa952a9194aa810582958a44a26450215504612a46414;
    op_a[0] = 194'h1;
    op_b[0] = b0;
    sb.push_back('{who: 4'b0001, prod: b0});
    s0  = starts;
    req = 4'b0001;
    t0  = cyc;
    @(negedge clk);
    chk("single_gnt_start", EW'(gnt), EW'(4'b0001));
    chk("single_mreset", EW'(mult_reset), EW'(1));
    wait_done(to);
    chk("single_timeout", EW'(to), EW'(0));
    chk("single_latency", EW'(cyc - t0), EW'(8));
    chk("single_c", c, b0);
    req = '0;
    settle_and_audit(s0, 1, "single");

    for (int v = 0; v < 5; v++) run_vec(vecs[v], 1'b1);

    // Stale done level held across the start pulse.
    stale_lag = 1'b1;
    run_vec('{req: 4'b0010, hold: 1'b0, nops: 3'd1, order: 20'h00002}, 1'b0);
    run_vec('{req: 4'b0010, hold: 1'b0, nops: 3'd1, order: 20'h00002}, 1'b0);
    stale_lag = 1'b0;
    repeat (10) @(negedge clk);

    // Requester 2 drops req during the second WAIT cycle.
    op_a[2] = rand_elem();
    op_b[2] = rand_elem();
    push_exp(2);
    s0  = starts;
    req = 4'b0100;
    repeat (3) @(negedge clk);
    req = '0;
    wait_done(to);
    chk("drop_timeout", EW'(to), EW'(0));
    settle_and_audit(s0, 1, "drop");

    // Reset in the second WAIT cycle aborts with no done pulse.
    op_a[0] = rand_elem();
    op_b[0] = rand_elem();
    req = 4'b0001;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    chk("abort_gnt", EW'(gnt), EW'(0));
    chk("abort_done", EW'(done), EW'(0));
    chk("abort_c", c, '0);
    chk("abort_mreset", EW'(mult_reset), EW'(1));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s0 = starts;
    repeat (20) @(negedge clk);
    chk("abort_no_start", EW'(starts - s0), EW'(0));
    run_vec('{req: 4'b1000, hold: 1'b0, nops: 3'd1, order: 20'h00008}, 1'b1);

    // Operand isolation: requester 1 changes its operands while 0 is being served.
    op_a[0] = rand_elem();
    op_b[0] = rand_elem();
    push_exp(0);
    s0  = starts;
    req = 4'b0001;
    repeat (3) @(negedge clk);
    op_a[1] = rand_elem();
    op_b[1] = rand_elem();
    @(negedge clk);
    chk("iso_mult_a", mult_a, op_a[0]);
    chk("iso_mult_b", mult_b, op_b[0]);
    chk("iso_gnt", EW'(gnt), EW'(4'b0001));
    wait_done(to);
    chk("iso_timeout", EW'(to), EW'(0));
    req = '0;
    settle_and_audit(s0, 1, "iso");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
